payload_word_serializer: RTL and testbench
==========================================

Name: payload_word_serializer

Overview:
- Splits one DATA_SIZE-bit payload into WORD_COUNT words of WORD_SIZE bits and emits them one per handshake on a valid/ready stream.
- WORD_COUNT = get_word_count_for_size(DATA_SIZE, WORD_SIZE) from math_pkg. The index counter width uses math_pkg clog2.
- Sits between wide producers (register snapshots, descriptor builders) and narrow transport links (UART/AXI-stream framers) in the FPGA datapath.

Parameters:
- DATA_SIZE, 40, width of the input payload in bits (>=1).
- WORD_SIZE, 16, width of each output word in bits (>=1).
- WORD_COUNT, get_word_count_for_size(DATA_SIZE, WORD_SIZE), derived number of output words per payload. Local, not overridable.
- IDX_W, max(1, clog2(WORD_COUNT)), derived width of the word index. Local.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input payload valid.
- s_ready  out  1  block can accept a payload.
- s_data  in  DATA_SIZE  input payload.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  WORD_SIZE  current output word.
- m_last  out  1  marks the final word of a payload.
- m_idx  out  IDX_W  index of the current word, 0..WORD_COUNT-1.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, s_ready=1 (asserted in the first cycle after reset deasserts), m_valid=0, m_data=0, m_last=0, m_idx=0. Internal payload register is cleared to 0.
- FSM IDLE:
  - s_ready=1, m_valid=0.
  - On s_valid&&s_ready, latch s_data zero-extended to WORD_COUNT*WORD_SIZE bits, set idx=0, and go to SEND.
- FSM SEND:
  - s_ready=0, m_valid=1.
  - m_data = padded payload bits [idx*WORD_SIZE +: WORD_SIZE].
  - m_last = (idx==WORD_COUNT-1). m_idx = idx.
- SEND, on m_valid&&m_ready: if not last, idx<=idx+1; if last, idx<=0 and go to IDLE.
- Latency: first word is valid 1 cycle after the input handshake.
- Throughput: WORD_COUNT+1 cycles per payload with m_ready held high. One IDLE bubble between payloads is intentional.
- Ordering: word 0 holds the least-significant WORD_SIZE bits. The final word holds the remaining upper bits with zero padding in its MSBs.
- Stability: while m_valid && !m_ready, m_data, m_last and m_idx hold constant. m_valid is never deasserted without a handshake.
- Input hold: s_data is sampled only at the handshake. Changes at any other time are ignored.
- WORD_COUNT==1: a single beat with m_last=1. idx stays 0.
- Exact multiple (DATA_SIZE % WORD_SIZE == 0): no padding is inserted.
- s_valid asserted during SEND: ignored, because s_ready=0. No payload is lost; the upstream holds it.
- rst asserted mid-payload: remaining words are discarded and all outputs take their reset values on the next edge. No partial payload is replayed.
- m_ready asserted while m_valid=0: no effect.

Optional Feature:
- Macro: PAYLOAD_SER_MSW_FIRST_EN.
- Defined: word order is reversed. Word 0 is the most-significant word of the padded payload. Padding zeros therefore appear in the MSBs of the first word. m_last and m_idx semantics are unchanged (m_idx still counts beats 0..WORD_COUNT-1).
- Undefined: LSW-first order as described in Behaviour.

Test Plan:
- LSW order: DATA_SIZE=40, WORD_SIZE=16, s_data=40'h12_3456_789A, m_ready=1 -> beats 16'h789A (idx0), 16'h3456 (idx1), 16'h0012 (idx2, m_last=1). s_ready returns high the cycle after beat 2.
- Backpressure: same payload, m_ready low for 3 cycles during beat 1 -> m_data holds 16'h3456 and m_valid stays 1. The sequence completes unchanged once m_ready rises.
- Single word: DATA_SIZE=16, WORD_SIZE=16, s_data=16'hBEEF -> one beat 16'hBEEF with m_last=1 and m_idx=0. Back in IDLE next cycle.
- Blocking: s_valid held high with a second payload 40'hAA_BBCC_DDEE during SEND -> s_ready=0 until the first payload's last beat. Second payload is then accepted and emits EEDD... correctly (16'hDDEE, 16'hBBCC, 16'h00AA).
- Reset mid-frame: assert rst after beat 0 of 40'h12_3456_789A -> next cycle m_valid=0, m_data=0, m_idx=0, s_ready=1. A new payload starts at idx 0.
- Macro defined: s_data=40'h12_3456_789A -> beats 16'h0012, 16'h3456, 16'h789A with m_last on the third.

Source files
------------

// File: rtl/math_pkg.sv
// math_pkg: elaboration-time sizing helpers shared by datapath blocks.
package math_pkg;
    function automatic int clog2(input int value);
        int r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int get_word_count_for_size(input int data_size, input int word_size);
        return (data_size + word_size - 1) / word_size;
    endfunction

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/payload_word_serializer.sv
// payload_word_serializer: splits a wide payload into WORD_SIZE beats on a valid/ready stream.
// Define PAYLOAD_SER_MSW_FIRST_EN to emit the most-significant word first.
module payload_word_serializer #(
    parameter int DATA_SIZE = 40,
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_SIZE-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WORD_SIZE-1:0] m_data,
    output logic                 m_last,
    output logic [math_pkg::max(1, math_pkg::clog2(math_pkg::get_word_count_for_size(DATA_SIZE, WORD_SIZE)))-1:0] m_idx
);
    localparam int WORD_COUNT = math_pkg::get_word_count_for_size(DATA_SIZE, WORD_SIZE);
    localparam int IDX_W = math_pkg::max(1, math_pkg::clog2(WORD_COUNT));
    localparam int PAD_W = WORD_COUNT * WORD_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [PAD_W-1:0] payload, payload_nxt, shifted;
    int sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            payload <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            payload <= payload_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        payload_nxt = payload;
        s_ready     = (state == IDLE);
        m_valid     = (state == SEND);
        m_last      = m_valid && (idx == LAST_IDX);
        m_idx       = idx;
`ifdef PAYLOAD_SER_MSW_FIRST_EN
        sel         = WORD_COUNT - 1 - int'(idx);
`else
        sel         = int'(idx);
`endif
        shifted     = payload >> (sel * WORD_SIZE);
        m_data      = m_valid ? shifted[WORD_SIZE-1:0] : '0;
        if (s_valid && s_ready) begin
            payload_nxt = PAD_W'(s_data);
            idx_nxt     = '0;
            state_nxt   = SEND;
        end
        if (m_valid && m_ready) begin
            idx_nxt   = m_last ? '0 : idx + IDX_W'(1);
            state_nxt = m_last ? IDLE : SEND;
        end
    end
endmodule

// File: tb/tb_payload_word_serializer.sv
// tb_payload_word_serializer: directed checks of a 40/16 serializer and a 16/16 single-beat instance.
module tb_payload_word_serializer;
    logic        clk = 0;
    logic        rst = 1;
    logic        a_s_valid = 0, a_s_ready, a_m_valid, a_m_ready = 0, a_m_last;
    logic [39:0] a_s_data = '0;
    logic [15:0] a_m_data;
    logic [1:0]  a_m_idx;
    logic        b_s_valid = 0, b_s_ready, b_m_valid, b_m_ready = 1, b_m_last;
    logic [15:0] b_s_data = '0, b_m_data;
    logic [0:0]  b_m_idx;
    int n_checks = 0;
    int n_fails = 0;
    logic [15:0] p1 [3];
    logic [15:0] p2 [3];

    always #5 clk = ~clk;

    payload_word_serializer #(.DATA_SIZE(40), .WORD_SIZE(16)) u_a (
        .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last), .m_idx(a_m_idx)
    );

    payload_word_serializer #(.DATA_SIZE(16), .WORD_SIZE(16)) u_b (
        .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last), .m_idx(b_m_idx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [15:0] data, input int i);
        chk({tag, "_valid"}, 64'(a_m_valid), 64'd1);
        chk({tag, "_sready"}, 64'(a_s_ready), 64'd0);
        chk({tag, "_data"}, 64'(a_m_data), 64'(data));
        chk({tag, "_idx"}, 64'(a_m_idx), 64'(i));
        chk({tag, "_last"}, 64'(a_m_last), 64'(i == 2));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sready"}, 64'(a_s_ready), 64'd1);
        chk({tag, "_valid"}, 64'(a_m_valid), 64'd0);
        chk({tag, "_data"}, 64'(a_m_data), 64'd0);
        chk({tag, "_idx"}, 64'(a_m_idx), 64'd0);
        chk({tag, "_last"}, 64'(a_m_last), 64'd0);
    endtask

    initial begin
`ifdef PAYLOAD_SER_MSW_FIRST_EN
        p1 = '{16'h0012, 16'h3456, 16'h789A};
        p2 = '{16'h00AA, 16'hBBCC, 16'hDDEE};
`else
        p1 = '{16'h789A, 16'h3456, 16'h0012};
        p2 = '{16'hDDEE, 16'hBBCC, 16'h00AA};
`endif
        step();
        step();
        chk_idle("rst_a");
        chk("rst_b_sready", 64'(b_s_ready), 64'd1);
        chk("rst_b_valid", 64'(b_m_valid), 64'd0);
        rst = 0;
        a_m_ready = 1;
        step();
        chk_idle("idle_mready_no_effect");
        // Straight-through payload with m_ready held high
        a_s_valid = 1;
        a_s_data = 40'h12_3456_789A;
        step();
        a_s_valid = 0;
        a_s_data = 40'hFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("seq_b%0d", i), p1[i], i);
            step();
        end
        chk_idle("seq_done");
        a_s_valid = 1;
        a_s_data = 40'h12_3456_789A;
        step();
        a_s_valid = 0;
        chk_beat("bp_b0", p1[0], 0);
        step();
        a_m_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_beat($sformatf("bp_hold%0d", i), p1[1], 1);
        end
        a_m_ready = 1;
        step();
        chk_beat("bp_b2", p1[2], 2);
        step();
        chk_idle("bp_done");
        // Second payload offered during SEND must wait for the IDLE slot
        a_s_valid = 1;
        a_s_data = 40'h12_3456_789A;
        step();
        a_s_data = 40'hAA_BBCC_DDEE;
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("blk_p1_b%0d", i), p1[i], i);
            step();
        end
        chk("blk_gap_sready", 64'(a_s_ready), 64'd1);
        step();
        a_s_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("blk_p2_b%0d", i), p2[i], i);
            step();
        end
        chk_idle("blk_done");
        a_s_valid = 1;
        a_s_data = 40'h12_3456_789A;
        step();
        a_s_valid = 0;
        chk_beat("rstmid_b0", p1[0], 0);
        step();
        rst = 1;
        step();
        chk_idle("rstmid_after");
        rst = 0;
        a_s_valid = 1;
        a_s_data = 40'hAA_BBCC_DDEE;
        step();
        a_s_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("rstmid_new_b%0d", i), p2[i], i);
            step();
        end
        chk_idle("rstmid_new_done");
        b_s_valid = 1;
        b_s_data = 16'hBEEF;
        step();
        b_s_valid = 0;
        chk("single_valid", 64'(b_m_valid), 64'd1);
        chk("single_data", 64'(b_m_data), 64'hBEEF);
        chk("single_last", 64'(b_m_last), 64'd1);
        chk("single_idx", 64'(b_m_idx), 64'd0);
        chk("single_sready", 64'(b_s_ready), 64'd0);
        step();
        chk("single_done_valid", 64'(b_m_valid), 64'd0);
        chk("single_done_sready", 64'(b_s_ready), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
